// File: rtl/aq_reduce_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aq_reduce_accum : weighted pixel accumulator with rounding divide for image reduce
// Revision: 1.0
// ---------------------------------------------------------------------------
module aq_reduce_accum (
  input  logic        RST_N,
  input  logic        CLK,
  input  logic [15:0] ORG,
  input  logic        S_TVALID,
  output logic        S_TREADY,
  input  logic [7:0]  S_TDATA,
  input  logic        S_TLAST,
  output logic        CALC_ENA,
  output logic        CALC_START,
  input  logic        CALC_VALID,
  input  logic [15:0] CALC_MA,
  input  logic [15:0] CALC_MB,
  output logic        M_TVALID,
  input  logic        M_TREADY,
  output logic [7:0]  M_TDATA,
  output logic        M_TLAST
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_pix;
  logic        r_tlast;
  logic        r_first;
  logic [23:0] r_acc;
  logic [24:0] r_rem;
  logic [2:0]  r_cnt;
  logic [7:0]  r_q;
  logic        r_sat;
  logic [7:0]  r_mdata;
  logic        r_mlast;

  logic        w_accept;
  logic        w_emit;
  logic [23:0] w_prod_ma;
  logic [23:0] w_prod_mb;
  logic [23:0] w_sum;
  logic [24:0] w_num;
  logic [2:0]  w_bit;
  logic [24:0] w_dshift;
  logic        w_ge;
  logic        w_sat_now;
  logic [7:0]  w_qfinal;

  // Gated with reset so no strobe leaks to the calculator while held in reset
  assign w_accept  = S_TVALID & (r_state == ST_IDLE) & RST_N;
  assign w_emit    = CALC_VALID | r_tlast;
  assign w_prod_ma = {16'd0, r_pix} * {8'd0, CALC_MA};
  assign w_prod_mb = {16'd0, r_pix} * {8'd0, CALC_MB};
  assign w_sum     = r_acc + (CALC_VALID ? w_prod_ma : w_prod_mb);
  assign w_num     = {1'b0, w_sum} + {10'd0, ORG[15:1]};

  // One quotient bit per DIV cycle, MSB first; saturation test shares cycle 0
  assign w_bit     = 3'd7 - r_cnt;
  assign w_dshift  = {9'd0, ORG} << w_bit;
  assign w_ge      = (r_rem >= w_dshift);
  assign w_sat_now = (r_rem >= {1'b0, ORG, 8'd0});
  assign w_qfinal  = r_sat ? 8'hFF : {r_q[6:0], w_ge};

  assign M_TDATA   = r_mdata;
  assign M_TLAST   = r_mlast;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    S_TREADY   = 1'b0;
    M_TVALID   = 1'b0;
    CALC_ENA   = w_accept;
    CALC_START = w_accept & r_first;
    case (r_state)
      ST_IDLE: begin
        S_TREADY = 1'b1;
        if (w_accept) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_next = w_emit ? ST_DIV : ST_IDLE;
      end
      ST_DIV: begin
        if (r_cnt == 3'd7) w_next = ST_OUT;
      end
      ST_OUT: begin
        M_TVALID = 1'b1;
        if (M_TREADY) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pix   <= 8'd0;
      r_tlast <= 1'b0;
      r_first <= 1'b1;
      r_acc   <= 24'd0;
      r_rem   <= 25'd0;
      r_cnt   <= 3'd0;
      r_q     <= 8'd0;
      r_sat   <= 1'b0;
      r_mdata <= 8'd0;
      r_mlast <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pix   <= S_TDATA;
            r_tlast <= S_TLAST;
            r_first <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (w_emit) begin
            r_rem <= w_num;
            r_q   <= 8'd0;
            r_cnt <= 3'd0;
            r_acc <= (CALC_VALID & ~r_tlast) ? w_prod_mb : 24'd0;
          end else begin
            r_acc <= r_acc + w_prod_mb;
          end
          if (r_tlast) r_first <= 1'b1;
        end
        ST_DIV: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd0) r_sat <= w_sat_now;
          r_q <= {r_q[6:0], w_ge};
          if (w_ge) r_rem <= r_rem - w_dshift;
          if (r_cnt == 3'd7) begin
            r_mdata <= w_qfinal;
            r_mlast <= r_tlast;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aq_reduce_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aq_reduce_accum : directed + randomized bench against an arithmetic reference
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_aq_reduce_accum;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] ORG = 16'd0;
  logic        S_TVALID = 1'b0;
  logic        S_TREADY;
  logic [7:0]  S_TDATA = 8'd0;
  logic        S_TLAST = 1'b0;
  logic        CALC_ENA;
  logic        CALC_START;
  logic        CALC_VALID = 1'b0;
  logic [15:0] CALC_MA = 16'd0;
  logic [15:0] CALC_MB = 16'd0;
  logic        M_TVALID;
  logic        M_TREADY = 1'b0;
  logic [7:0]  M_TDATA;
  logic        M_TLAST;

  aq_reduce_accum u_dut (
    .RST_N      (RST_N),
    .CLK        (CLK),
    .ORG        (ORG),
    .S_TVALID   (S_TVALID),
    .S_TREADY   (S_TREADY),
    .S_TDATA    (S_TDATA),
    .S_TLAST    (S_TLAST),
    .CALC_ENA   (CALC_ENA),
    .CALC_START (CALC_START),
    .CALC_VALID (CALC_VALID),
    .CALC_MA    (CALC_MA),
    .CALC_MB    (CALC_MB),
    .M_TVALID   (M_TVALID),
    .M_TREADY   (M_TREADY),
    .M_TDATA    (M_TDATA),
    .M_TLAST    (M_TLAST)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: running weighted sum and start-of-line flag
  int m_acc   = 0;
  bit m_first = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_div(input int sum, input int org);
    int q;
    if (org == 0) return 255;
    q = (sum + org / 2) / org;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic scramble_calc();
    CALC_VALID = 1'($urandom_range(0, 1));
    CALC_MA    = 16'($urandom);
    CALC_MB    = 16'($urandom);
  endtask

  // hold < 0: random early-ready / backpressure; hold >= 0: fixed stall cycles
  task automatic send(input int pix, input bit last, input bit vld, input int ma,
                      input int mb, input int org, input int hold);
    int  exp_q;
    int  sum;
    int  cyc;
    int  holdn;
    bit  emit;
    bit  exp_start;
    bit  early;

    emit  = vld | last;
    exp_q = 0;
    if (emit) begin
      sum   = m_acc + pix * (vld ? ma : mb);
      exp_q = ref_div(sum, org);
      m_acc = (vld && !last) ? pix * mb : 0;
    end else begin
      m_acc = m_acc + pix * mb;
    end
    exp_start = m_first;
    m_first   = last;

    ORG      = 16'(org);
    S_TDATA  = 8'(pix);
    S_TLAST  = last;
    S_TVALID = 1'b1;
    scramble_calc();
    #1;
    chk("s_tready_idle", 32'(S_TREADY), 32'd1);
    chk("calc_ena", 32'(CALC_ENA), 32'd1);
    chk("calc_start", 32'(CALC_START), 32'(exp_start));

    step();
    S_TVALID   = 1'($urandom_range(0, 1));
    S_TDATA    = 8'($urandom);
    S_TLAST    = 1'($urandom_range(0, 1));
    CALC_VALID = vld;
    CALC_MA    = 16'(ma);
    CALC_MB    = 16'(mb);
    #1;
    chk("s_tready_wait", 32'(S_TREADY), 32'd0);
    chk("calc_ena_wait", 32'(CALC_ENA), 32'd0);

    step();
    S_TVALID = 1'b0;
    scramble_calc();
    if (!emit) begin
      chk("s_tready_back", 32'(S_TREADY), 32'd1);
      return;
    end

    if (hold < 0) begin
      early = 1'($urandom_range(0, 1));
      holdn = early ? 0 : $urandom_range(0, 3);
    end else begin
      early = 1'b0;
      holdn = hold;
    end
    M_TREADY = early;
    cyc = 2;
    while (!M_TVALID && cyc < 40) begin
      step();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd10);
    chk("m_tdata", 32'(M_TDATA), 32'(exp_q));
    chk("m_tlast", 32'(M_TLAST), 32'(last));

    for (int h = 0; h < holdn; h++) begin
      S_TVALID = 1'b1;
      #1;
      chk("calc_ena_out", 32'(CALC_ENA), 32'd0);
      step();
      chk("m_tvalid_hold", 32'(M_TVALID), 32'd1);
      chk("m_tdata_hold", 32'(M_TDATA), 32'(exp_q));
      chk("m_tlast_hold", 32'(M_TLAST), 32'(last));
      chk("s_tready_out", 32'(S_TREADY), 32'd0);
    end
    S_TVALID = 1'b0;
    M_TREADY = 1'b1;
    step();
    M_TREADY = 1'b0;
    chk("m_tvalid_done", 32'(M_TVALID), 32'd0);
    chk("s_tready_done", 32'(S_TREADY), 32'd1);
  endtask

  initial begin
    int never;
    int since;
    int cur_org;
    bit last;
    bit vld;

    // reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      S_TVALID = 1'($urandom_range(0, 1));
      S_TDATA  = 8'($urandom);
      M_TREADY = 1'($urandom_range(0, 1));
      #1;
      chk("rst_s_tready", 32'(S_TREADY), 32'd1);
      chk("rst_m_tvalid", 32'(M_TVALID), 32'd0);
      chk("rst_m_tdata", 32'(M_TDATA), 32'd0);
      chk("rst_calc_start", 32'(CALC_START), 32'd0);
      chk("rst_calc_ena", 32'(CALC_ENA), 32'd0);
      step();
    end
    S_TVALID = 1'b0;
    M_TREADY = 1'b0;
    RST_N    = 1'b1;
    step();

    // basic reduce: (20 + 60 + 2) / 4 = 20
    send(10, 0, 0, 0, 2, 4, 0);
    send(30, 0, 1, 2, 0, 4, 0);
    // rounding and saturation
    send(10, 0, 1, 3, 0, 3, 0);
    send(255, 0, 1, 2, 0, 1, 0);
    send(7, 0, 1, 1, 0, 0, 0);
    // line end flush, then new line starts from zero
    send(40, 1, 0, 0, 2, 4, 0);
    send(8, 0, 1, 4, 0, 4, 0);
    // backpressure
    send(100, 0, 1, 1, 0, 1, 5);

    // reset in the middle of a divide
    ORG      = 16'd4;
    S_TDATA  = 8'd50;
    S_TLAST  = 1'b0;
    S_TVALID = 1'b1;
    step();
    S_TVALID   = 1'b0;
    CALC_VALID = 1'b1;
    CALC_MA    = 16'd4;
    CALC_MB    = 16'd3;
    step();
    scramble_calc();
    for (int i = 0; i < 3; i++) step();
    RST_N    = 1'b0;
    S_TVALID = 1'b1;
    #1;
    chk("mid_rst_m_tvalid", 32'(M_TVALID), 32'd0);
    chk("mid_rst_s_tready", 32'(S_TREADY), 32'd1);
    chk("mid_rst_calc_ena", 32'(CALC_ENA), 32'd0);
    chk("mid_rst_m_tdata", 32'(M_TDATA), 32'd0);
    step();
    S_TVALID = 1'b0;
    RST_N    = 1'b1;
    m_acc    = 0;
    m_first  = 1'b1;
    never    = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (M_TVALID) never++;
    end
    chk("mid_rst_no_output", 32'(never), 32'd0);
    send(16, 0, 1, 2, 1, 4, 0);

    // randomized stream; VALID forced often enough to keep sums in range
    since   = 0;
    cur_org = $urandom_range(1, 2000);
    for (int i = 0; i < 60; i++) begin
      last = ($urandom_range(0, 9) == 0);
      vld  = (since == 7) || ($urandom_range(0, 2) == 0);
      send($urandom_range(0, 255), last, vld, $urandom_range(0, 4095),
           $urandom_range(0, 4095), cur_org, -1);
      since = (vld || last) ? 0 : since + 1;
      if (last) cur_org = ($urandom_range(0, 8) == 0) ? 0 : $urandom_range(1, 2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
